// File: rtl/seq_multdiv.sv
// Multi-cycle signed 32-bit multiply/divide: radix-2 shift-add MULT, non-restoring DIV,
// both sharing one add/sub datapath. One iteration per cycle, result registered on exit.
module seq_multdiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mul_q, mul_d;
    logic            sign_q, sign_d;
    logic [W:0]      hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            exc_q, exc_d;
    logic            rdy_q, rdy_d;

    logic            start;
    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      add_a, add_b, sum;
    logic            sub;
    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    quot_s;

    assign start = ctrl_MULT | ctrl_DIV;
    // Two's-complement negation of INT_MIN yields the same bits, read as unsigned 2^(W-1).
    assign mag_a = data_operandA[W-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[W-1] ? -data_operandB : data_operandB;

    // Shared adder: MULT adds the multiplicand into the high half; DIV adds or subtracts
    // the divisor from the left-shifted partial remainder depending on its sign.
    always_comb begin
        add_a  = mul_q ? hi_q : {hi_q[W-1:0], lo_q[W-1]};
        add_b  = (mul_q && !lo_q[0]) ? '0 : {1'b0, b_q};
        sub    = !mul_q && !hi_q[W];
        sum    = sub ? (add_a - add_b) : (add_a + add_b);
        prod_s = sign_q ? -{hi_q[W-1:0], lo_q} : {hi_q[W-1:0], lo_q};
        quot_s = sign_q ? -lo_q : lo_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_d    = mul_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            mul_d   = ctrl_MULT;
            sign_d  = data_operandA[W-1] ^ data_operandB[W-1];
            hi_d    = '0;
            lo_d    = ctrl_MULT ? mag_b : mag_a;
            b_d     = ctrl_MULT ? mag_a : mag_b;
        end else begin
            case (state_q)
                RUN: begin
                    if (mul_q) begin
                        hi_d = {1'b0, sum[W:1]};
                        lo_d = {sum[0], lo_q[W-1:1]};
                    end else begin
                        hi_d = sum;
                        lo_d = {lo_q[W-2:0], ~sum[W]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                    if (mul_q) begin
                        result_d = prod_s[W-1:0];
                        exc_d    = !((&prod_s[2*W-1:W-1]) || !(|prod_s[2*W-1:W-1]));
                    end else if (b_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        // Only INT_MIN / -1 produces a positive quotient of 2^(W-1).
                        result_d = quot_s;
                        exc_d    = !sign_q && lo_q[W-1];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mul_q    <= mul_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != IDLE);

endmodule
